// File: rtl/count_seq_ctrl_pkg.sv
// Shared types and the fixed 14-entry value sequence for the counter sequencer.
package count_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DWELL,
    DONE,
    ERROR
  } state_t;

  localparam int         SEQ_LEN  = 14;
  localparam logic [3:0] LAST_IDX = 4'd13;

  // Packed with entry 0 in the least-significant nibble: 8,7,11,4,9,2,5,12,6,3,15,1,14,13.
  localparam logic [SEQ_LEN-1:0][3:0] SEQ = {
    4'd13, 4'd14, 4'd1, 4'd15, 4'd3, 4'd6, 4'd12,
    4'd5,  4'd2,  4'd9, 4'd4,  4'd11, 4'd7, 4'd8
  };

endpackage

// File: rtl/count_seq_rom.sv
// Combinational lookup of the sequence table; out-of-range indices read as 0.
module count_seq_rom
  import count_seq_pkg::*;
(
  input  logic [3:0] idx,
  output logic [3:0] value
);

  always_comb begin
    value = 4'd0;
    if (idx <= LAST_IDX) value = SEQ[idx];
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Walks a loadable 4-bit counter through the fixed sequence, verifying each load
// and dwelling between entries; reports done or a sticky error with the failing index.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter bit LOOP         = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic [3:0] cnt_value,
  output logic       cnt_load,
  output logic       cnt_enable,
  output logic [3:0] cnt_load_val,
  output logic       busy,
  output logic [3:0] seq_val,
  output logic       seq_valid,
  output logic       done,
  output logic       err,
  output logic [3:0] err_idx
);

  localparam logic [7:0] DWELL_RELOAD = 8'(DWELL_CYCLES - 1);

  state_t     state;
  logic [3:0] idx;
  logic [7:0] dwell;
  logic [3:0] rom_val;

  count_seq_rom u_rom (
    .idx   (idx),
    .value (rom_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      dwell     <= 8'd0;
      seq_val   <= 4'd0;
      seq_valid <= 1'b0;
      err_idx   <= 4'd0;
    end else begin
      seq_valid <= 1'b0;
      if (abort) begin
        state <= IDLE;
        idx   <= 4'd0;
        dwell <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= LOAD;
              idx   <= 4'd0;
            end
          end
          LOAD: state <= CHECK;
          CHECK: begin
            // The counter captured rom_val at the end of LOAD, so it must read back now.
            if (cnt_value == rom_val) begin
              seq_valid <= 1'b1;
              seq_val   <= rom_val;
              dwell     <= DWELL_RELOAD;
              state     <= DWELL;
            end else begin
              err_idx <= idx;
              state   <= ERROR;
            end
          end
          DWELL: begin
            if (!pause) begin
              if (dwell != 8'd0) begin
                dwell <= dwell - 8'd1;
              end else if (idx != LAST_IDX) begin
                idx   <= idx + 4'd1;
                state <= LOAD;
              end else if (LOOP) begin
                idx   <= 4'd0;
                state <= LOAD;
              end else begin
                state <= DONE;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            idx   <= 4'd0;
          end
          ERROR:   state <= ERROR;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cnt_load     = (state == LOAD);
  assign cnt_enable   = (state == LOAD);
  assign cnt_load_val = (state == LOAD) ? rom_val : 4'd0;
  assign busy         = (state == LOAD) || (state == CHECK) || (state == DWELL);
  assign done         = (state == DONE);
  assign err          = (state == ERROR);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: behavioural counters, scoreboard queues and directed scenarios.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, abort = 1'b0, pause = 1'b0, fault = 1'b0;
  logic [3:0] cnt0, cnt_load_val, seq_val, err_idx;
  logic       cnt_load, cnt_enable, busy, seq_valid, done, err;

  logic       start1 = 1'b0;
  logic [3:0] cnt1, load_val1, seq_val1, err_idx1;
  logic       load1, enable1, busy1, valid1, done1, err1;

  int tests = 0, fails = 0, cyc = 0;
  int load_q[$], val_q[$], loads1[$];
  int first_load_cyc = -1, last_load_cyc = -1, done_cyc = -1, done_cnt = 0, done1_cnt = 0;
  bit arm_first = 1'b0;
  int exp_seq[14] = '{8, 7, 11, 4, 9, 2, 5, 12, 6, 3, 15, 1, 14, 13};

  count_seq_ctrl #(.DWELL_CYCLES(4), .LOOP(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .cnt_value(cnt0), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_load_val(cnt_load_val), .busy(busy), .seq_val(seq_val),
    .seq_valid(seq_valid), .done(done), .err(err), .err_idx(err_idx)
  );

  count_seq_ctrl #(.DWELL_CYCLES(4), .LOOP(1'b1)) dut_loop (
    .clk(clk), .reset(reset), .start(start1), .abort(1'b0), .pause(1'b0),
    .cnt_value(cnt1), .cnt_load(load1), .cnt_enable(enable1),
    .cnt_load_val(load_val1), .busy(busy1), .seq_val(seq_val1),
    .seq_valid(valid1), .done(done1), .err(err1), .err_idx(err_idx1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Loadable counters; 'fault' corrupts a load of 4 into 5.
  always @(posedge clk) begin
    if (reset) cnt0 <= 4'd0;
    else if (cnt_load) cnt0 <= (fault && cnt_load_val == 4'd4) ? 4'd5 : cnt_load_val;
    else if (cnt_enable) cnt0 <= cnt0 + 4'd1;
    if (reset) cnt1 <= 4'd0;
    else if (load1) cnt1 <= load_val1;
    else if (enable1) cnt1 <= cnt1 + 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a load or a verified value.
  always @(negedge clk) begin
    if (cnt_load) begin
      if (arm_first) begin
        first_load_cyc = cyc;
        arm_first = 1'b0;
      end
      last_load_cyc = cyc;
      if (load_q.size() == 0) chk("unexpected_load", int'(cnt_load_val), -1);
      else chk("load_val", int'(cnt_load_val), load_q.pop_front());
    end
    if (seq_valid) begin
      if (val_q.size() == 0) chk("unexpected_seq_valid", int'(seq_val), -1);
      else chk("seq_val", int'(seq_val), val_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (load1) loads1.push_back(int'(load_val1));
    if (done1) done1_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step(); start = 1'b1;
    step(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    step(); abort = 1'b1;
    step(); abort = 1'b0;
  endtask

  task automatic wait_load(input string name, input int budget);
    int n = 0;
    do begin samp(); n++; end while (!cnt_load && n < budget);
    chk(name, int'(cnt_load), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin samp(); n++; end while (!done && n < budget);
    chk(name, int'(done), 1);
  endtask

  function automatic int outs0();
    return int'({cnt_load, cnt_enable, cnt_load_val, busy, seq_val, seq_valid, done, err, err_idx});
  endfunction

  initial begin
    int n;
    // Reset state
    step(); step(); samp();
    chk("reset_outputs", outs0(), 0);
    chk("reset_outputs_loop_dut",
        int'({load1, enable1, load_val1, busy1, seq_val1, valid1, done1, err1, err_idx1}), 0);
    step(); reset = 1'b0;

    // 1: clean non-looping run
    foreach (exp_seq[i]) begin load_q.push_back(exp_seq[i]); val_q.push_back(exp_seq[i]); end
    arm_first = 1'b1; done_cnt = 0;
    pulse_start();
    wait_done("s1_done_seen", 300);
    chk("s1_done_latency", done_cyc - first_load_cyc, 84);
    chk("s1_err", int'(err), 0);
    samp();
    chk("s1_done_one_cycle", int'(done), 0);
    chk("s1_done_count", done_cnt, 1);
    chk("s1_busy_after", int'(busy), 0);
    chk("s1_loads_left", load_q.size(), 0);
    chk("s1_vals_left", val_q.size(), 0);

    // 2: corrupted load of entry 3
    fault = 1'b1;
    for (int i = 0; i < 4; i++) load_q.push_back(exp_seq[i]);
    for (int i = 0; i < 3; i++) val_q.push_back(exp_seq[i]);
    pulse_start();
    n = 0;
    do begin samp(); n++; end while (!err && n < 100);
    chk("s2_err_set", int'(err), 1);
    chk("s2_err_delay", cyc - last_load_cyc, 2);
    chk("s2_err_idx", int'(err_idx), 3);
    pulse_start();
    repeat (10) samp();
    chk("s2_err_sticky", int'(err), 1);
    chk("s2_busy_in_error", int'(busy), 0);
    pulse_abort();
    samp();
    chk("s2_err_cleared", int'(err), 0);
    chk("s2_busy_after_abort", int'(busy), 0);
    chk("s2_err_idx_kept", int'(err_idx), 3);
    chk("s2_loads_left", load_q.size(), 0);
    fault = 1'b0;

    // 3: pause stretches the dwell of entry 0 by 10 cycles
    foreach (exp_seq[i]) begin load_q.push_back(exp_seq[i]); val_q.push_back(exp_seq[i]); end
    arm_first = 1'b1; done_cnt = 0;
    pulse_start();
    wait_load("s3_first_load", 20);
    step();
    step(); pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      samp();
      chk($sformatf("s3_cnt_hold_%0d", i), int'(cnt0), 8);
      step();
    end
    pause = 1'b0;
    wait_load("s3_second_load", 40);
    chk("s3_second_load_delay", cyc - first_load_cyc, 16);
    chk("s3_second_load_val", int'(cnt_load_val), 7);
    wait_done("s3_done_seen", 300);
    chk("s3_done_latency", done_cyc - first_load_cyc, 94);
    chk("s3_vals_left", val_q.size(), 0);

    // 4: start+abort together, then abort mid-dwell, then restart
    step(); start = 1'b1; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0;
    samp(); chk("s4_abort_priority", int'(busy), 0);
    samp(); chk("s4_still_idle", int'(busy), 0);
    for (int i = 0; i < 7; i++) begin load_q.push_back(exp_seq[i]); val_q.push_back(exp_seq[i]); end
    done_cnt = 0;
    pulse_start();
    n = 0;
    do begin samp(); n++; end while (!(seq_valid && seq_val == 4'd5) && n < 100);
    chk("s4_entry6_verified", int'(seq_valid), 1);
    pulse_abort();
    samp();
    chk("s4_idle_after_abort", int'(busy), 0);
    chk("s4_no_load_after_abort", int'(cnt_load), 0);
    repeat (20) samp();
    chk("s4_no_done", done_cnt, 0);
    chk("s4_loads_left", load_q.size(), 0);
    load_q.push_back(8);
    pulse_start();
    wait_load("s4_restart_load", 20);
    chk("s4_restart_val", int'(cnt_load_val), 8);
    pulse_abort();

    // 6: reset during CHECK of entry 5 beats a simultaneous start
    for (int i = 0; i < 6; i++) load_q.push_back(exp_seq[i]);
    for (int i = 0; i < 5; i++) val_q.push_back(exp_seq[i]);
    pulse_start();
    n = 0;
    do begin samp(); n++; end while (!(cnt_load && cnt_load_val == 4'd2) && n < 100);
    chk("s6_entry5_load", int'(cnt_load), 1);
    step(); reset = 1'b1; start = 1'b1;
    step();
    samp();
    chk("s6_outputs_after_reset", outs0(), 0);
    chk("s6_vals_left", val_q.size(), 0);
    load_q.push_back(8);
    step(); reset = 1'b0;
    step(); start = 1'b0;
    samp();
    chk("s6_restart_from_idx0", int'(cnt_load_val), 8);
    pulse_abort();
    chk("s6_loads_left", load_q.size(), 0);

    // 5: looping instance wraps from entry 13 back to entry 0 and never reports done
    step(); start1 = 1'b1;
    step(); start1 = 1'b0;
    repeat (200) samp();
    chk("s5_enough_loads", int'(loads1.size() >= 16), 1);
    for (int i = 0; i < loads1.size(); i++)
      chk($sformatf("s5_load_%0d", i), loads1[i], exp_seq[i % 14]);
    chk("s5_no_done", done1_cnt, 0);
    chk("s5_no_err", int'(err1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
